// File: rtl/moore_ol_pkg.sv
// moore_ol_pkg: shared definitions for the 1101 overlapping sequence detector.
// Holds the FSM state type, the target pattern and the default width of the
// optional detection counter (enabled by defining MOORE_OL_DET_CNT_EN).
package moore_ol_pkg;

    // One state per matched prefix length of 1101; S4 means a full match.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    // Pattern being recognised, oldest bit in the MSB.
    localparam logic [3:0] PATTERN = 4'b1101;

    // Default width of the saturating detection counter.
    localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/moore_ol_cnt.sv
// moore_ol_cnt: saturating up-counter used to tally detections.
// Only instantiated when MOORE_OL_DET_CNT_EN is defined.
module moore_ol_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Clear while reset is low; otherwise count up on request and stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/moore_ol.sv
// moore_ol: Moore FSM detecting the serial pattern 1101 with overlap.
// out is decoded from the state register alone, so it rises the cycle after
// the final 1 is sampled and lasts exactly one cycle.
// Optional feature: define MOORE_OL_DET_CNT_EN to add the det_cnt port, a
// saturating count of detections that rises together with out.
module moore_ol
    import moore_ol_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
`ifdef MOORE_OL_DET_CNT_EN
    output logic [CNT_W-1:0] det_cnt,
`endif
    output logic             out
);

    state_t r_state;
    state_t w_next_state;

    // Next-state decode; from S4 a new 1 keeps the trailing "11" as a prefix, and stray encodings fall back to S0.
    always_comb begin
        w_next_state = S0;
        case (r_state)
            S0:      w_next_state = in ? S1 : S0;
            S1:      w_next_state = in ? S2 : S0;
            S2:      w_next_state = in ? S2 : S3;
            S3:      w_next_state = in ? S4 : S0;
            S4:      w_next_state = in ? S2 : S0;
            default: w_next_state = S0;
        endcase
    end

    // State register; a low reset wins over any transition, including one into S4.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S0;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign out = (r_state == S4);

`ifdef MOORE_OL_DET_CNT_EN
    logic w_enter_s4;

    assign w_enter_s4 = (w_next_state == S4);

    moore_ol_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_enter_s4),
        .o_count (det_cnt)
    );
`endif

endmodule

// File: tb/tb_moore_ol.sv
// tb_moore_ol: self-checking bench for moore_ol.
// Compares out (and det_cnt when MOORE_OL_DET_CNT_EN is defined) every cycle
// against a sliding-window model of the last four bits seen since reset.
module tb_moore_ol;
    import moore_ol_pkg::PATTERN;

`ifdef MOORE_OL_DET_CNT_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 8;
`endif
    localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

    logic clk;
    logic reset;
    logic in;
    logic out;
`ifdef MOORE_OL_DET_CNT_EN
    logic [TB_CNT_W-1:0] det_cnt;
`endif

    int checks;
    int errors;

    logic [3:0] hist;
    int         nBits;
    logic       expOut;
    int         expCnt;

    moore_ol #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
`ifdef MOORE_OL_DET_CNT_EN
        .det_cnt (det_cnt),
`endif
        .out     (out)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare DUT outputs against the window model.
    task automatic checkOutput(input string tag);
        checks++;
        assert (out === expOut)
        else begin
            errors++;
            $error("[TB] FAIL %s: out=%0b expected %0b", tag, out, expOut);
        end
`ifdef MOORE_OL_DET_CNT_EN
        checks++;
        assert (det_cnt === TB_CNT_W'(expCnt))
        else begin
            errors++;
            $error("[TB] FAIL %s_cnt: det_cnt=%0d expected %0d", tag, det_cnt, expCnt);
        end
`endif
    endtask

    // Drive one bit and reset level, clock one edge, advance the model, then check.
    task automatic applyStimulus(input logic b, input logic r, input string tag);
        in    = b;
        reset = r;
        @(posedge clk);
        if (!r) begin
            hist   = 4'b0000;
            nBits  = 0;
            expOut = 1'b0;
            expCnt = 0;
        end else begin
            hist = {hist[2:0], b};
            if (nBits < 4) nBits++;
            expOut = (nBits >= 4) && (hist == PATTERN);
            if (expOut && expCnt < CNT_MAX) expCnt++;
        end
        #1;
        checkOutput(tag);
    endtask

    // Feed a bit string (MSB first) with reset released.
    task automatic applySeq(input logic [15:0] bits, input int len, input string tag);
        for (int i = len - 1; i >= 0; i--) begin
            applyStimulus(bits[i], 1'b1, tag);
        end
    endtask

    // Directed scenarios followed by a randomized run.
    initial begin
        checks = 0;
        errors = 0;
        hist   = 4'b0000;
        nBits  = 0;
        expOut = 1'b0;
        expCnt = 0;
        in     = 1'b0;
        reset  = 1'b0;

        // Reset held two edges with random input, then released with in=0.
        applyStimulus(1'($urandom), 1'b0, "reset0");
        applyStimulus(1'($urandom), 1'b0, "reset1");
        applyStimulus(1'b0, 1'b1, "release");

        // Mid-sequence reset discards the 110 prefix.
        applySeq(16'b110, 3, "midrst_pre");
        applyStimulus(1'b1, 1'b0, "midrst_rst");
        applyStimulus(1'b1, 1'b1, "midrst_one");
        applyStimulus(1'b0, 1'b1, "midrst_zero");
        applySeq(16'b1101, 4, "midrst_det");
        applyStimulus(1'b0, 1'b1, "midrst_fall");

        // Single detect then fall.
        applySeq(16'b1101, 4, "single");
        applyStimulus(1'b0, 1'b1, "single_fall");

        // Overlapping detects at spacing 3.
        applySeq(16'b1101101, 7, "overlap");
        applyStimulus(1'b0, 1'b1, "overlap_fall");

        // Near misses: S2 self-loop still detects, 1011001 never does.
        applySeq(16'b11101, 5, "near_loop");
        applyStimulus(1'b0, 1'b1, "near_fall");
        applySeq(16'b1011001, 7, "near_none");

        // Reset coinciding with a would-be entry into S4.
        applyStimulus(1'b0, 1'b0, "clash_clr");
        applySeq(16'b110, 3, "clash_pre");
        applyStimulus(1'b1, 1'b0, "clash_rst");
        applyStimulus(1'b0, 1'b1, "clash_after");

        // Random stream with occasional resets.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'($urandom), ($urandom_range(0, 39) != 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
